// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry unit.
package keypad_pkg;

   localparam int unsigned KEY_W      = 4;
   localparam int unsigned ROWS       = 4;
   localparam int unsigned COLS       = 3;
   localparam int unsigned ENTRY_W    = 10;
   localparam int unsigned DIGITS_W   = 2;
   localparam int unsigned VALUE_W    = 8;
   localparam int unsigned MAX_DIGITS = 3;
   localparam int unsigned VALUE_MAX  = 255;

   localparam logic [KEY_W-1:0] KEY_STAR = 4'd10;
   localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;
   localparam logic [KEY_W-1:0] KEY_NONE = 4'd15;

   typedef enum logic [1:0] {
      SCAN_NONE,
      SCAN_SINGLE,
      SCAN_MULTI
   } scan_res_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } db_state_e;

   // Matrix position to key code: rows 0-2 are 1-9, row 3 is * 0 #.
   function automatic logic [KEY_W-1:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      logic [KEY_W-1:0] code;
      code = KEY_NONE;
      if (row != 2'd3) begin
         code = KEY_W'(row * 2'd3) + KEY_W'(col) + KEY_W'(1);
      end else begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = KEY_W'(0);
            default: code = KEY_HASH;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_entry_unit_scanner.sv
// Column drive, row synchroniser and per-scan key detection for a 4x3 keypad.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [ROWS-1:0]    key_row,
   output logic [COLS-1:0]    key_col,
   output logic               scan_done_c,
   output scan_res_e          scan_res_c,
   output logic [KEY_W-1:0]   scan_code_c
);

   localparam int unsigned SLOT_W = $clog2(SCAN_DIV);

   logic [ROWS-1:0]   row_meta_q, row_sync_q;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [1:0]        col_q, col_d;
   logic [COLS-1:0]   key_col_q, key_col_d;
   logic [1:0]        acc_hits_q, acc_hits_d;
   logic [KEY_W-1:0]  acc_code_q, acc_code_d;

   logic [ROWS-1:0]   pressed;
   logic [2:0]        col_hits, total_hits;
   logic [1:0]        hits_sat;
   logic [KEY_W-1:0]  col_code, code_new;
   logic              slot_end;

   always_comb begin
      pressed  = ~row_sync_q;
      col_hits = 3'd0;
      col_code = KEY_NONE;
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (pressed[r]) begin
            if (col_hits == 3'd0) col_code = key_lookup(2'(r), col_q);
            col_hits = col_hits + 3'd1;
         end
      end

      // Scan accumulator saturates at 2: anything beyond one key is MULTI.
      total_hits = 3'(acc_hits_q) + col_hits;
      hits_sat   = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
      code_new   = (col_hits != 3'd0) ? col_code : acc_code_q;

      slot_end    = enable && (slot_q == SLOT_W'(SCAN_DIV - 1));
      scan_done_c = slot_end && (col_q == 2'd2);
      scan_code_c = code_new;
      case (hits_sat)
         2'd0:    scan_res_c = SCAN_NONE;
         2'd1:    scan_res_c = SCAN_SINGLE;
         default: scan_res_c = SCAN_MULTI;
      endcase

      slot_d     = slot_q;
      col_d      = col_q;
      acc_hits_d = acc_hits_q;
      acc_code_d = acc_code_q;
      if (!enable) begin
         slot_d     = '0;
         col_d      = 2'd0;
         acc_hits_d = 2'd0;
         acc_code_d = KEY_NONE;
      end else if (slot_end) begin
         slot_d = '0;
         col_d  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
         if (scan_done_c) begin
            acc_hits_d = 2'd0;
            acc_code_d = KEY_NONE;
         end else begin
            acc_hits_d = hits_sat;
            acc_code_d = code_new;
         end
      end else begin
         slot_d = slot_q + SLOT_W'(1);
      end

      key_col_d = enable ? ~(COLS'(1) << col_d) : '1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         row_meta_q <= '1;
         row_sync_q <= '1;
         slot_q     <= '0;
         col_q      <= 2'd0;
         key_col_q  <= '1;
         acc_hits_q <= 2'd0;
         acc_code_q <= KEY_NONE;
      end else begin
         row_meta_q <= key_row;
         row_sync_q <= row_meta_q;
         slot_q     <= slot_d;
         col_q      <= col_d;
         key_col_q  <= key_col_d;
         acc_hits_q <= acc_hits_d;
         acc_code_q <= acc_code_d;
      end
   end

   assign key_col = key_col_q;

endmodule

// File: rtl/keypad_entry_unit.sv
// Keypad entry: debounces scanned presses and accumulates up to three digits, committing on '#'.
module keypad_entry_unit
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned DEBOUNCE_CNT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [ROWS-1:0]       key_ROW,
   output logic [COLS-1:0]       key_COL,
   output logic                  key_pulse,
   output logic [KEY_W-1:0]      key_code,
   output logic [ENTRY_W-1:0]    entry_value,
   output logic [DIGITS_W-1:0]   entry_digits,
   output logic [VALUE_W-1:0]    value,
   output logic                  value_valid
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

   logic             scan_done_c;
   scan_res_e        scan_res_c;
   logic [KEY_W-1:0] scan_code_c;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .key_row     (key_ROW),
      .key_col     (key_COL),
      .scan_done_c (scan_done_c),
      .scan_res_c  (scan_res_c),
      .scan_code_c (scan_code_c)
   );

   db_state_e            state_q, state_d;
   logic [KEY_W-1:0]     cand_q, cand_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
   logic                 key_pulse_q, key_pulse_d;
   logic [KEY_W-1:0]     key_code_q, key_code_d;
   logic [ENTRY_W-1:0]   entry_value_q, entry_value_d;
   logic [DIGITS_W-1:0]  entry_digits_q, entry_digits_d;
   logic [VALUE_W-1:0]   value_q, value_d;
   logic                 value_valid_q, value_valid_d;

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      cnt_inc     = cnt_q + CNT_W'(1);
      key_pulse_d = 1'b0;
      key_code_d  = key_code_q;

      // Debounce advances once per completed scan.
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (scan_done_c) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_res_c == SCAN_SINGLE) begin
                  state_d = ST_DEBOUNCE;
                  cand_d  = scan_code_c;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_DEBOUNCE: begin
               if (scan_res_c == SCAN_SINGLE && scan_code_c == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                     state_d     = ST_HELD;
                     key_pulse_d = 1'b1;
                     key_code_d  = cand_q;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (scan_res_c == SCAN_NONE) begin
                  state_d = ST_RELEASE;
                  cnt_d   = CNT_W'(1);
               end
            end
            default: begin
               if (scan_res_c != SCAN_NONE) begin
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) state_d = ST_IDLE;
               end
            end
         endcase
      end

      entry_value_d  = entry_value_q;
      entry_digits_d = entry_digits_q;
      value_d        = value_q;
      value_valid_d  = 1'b0;

      // Accumulator acts on the key accepted in the previous cycle.
      if (key_pulse_q && enable) begin
         if (key_code_q == KEY_STAR) begin
            entry_value_d  = '0;
            entry_digits_d = '0;
         end else if (key_code_q == KEY_HASH) begin
            if (entry_digits_q != '0) begin
               value_d        = (entry_value_q > ENTRY_W'(VALUE_MAX)) ? VALUE_W'(VALUE_MAX)
                                                                      : entry_value_q[VALUE_W-1:0];
               value_valid_d  = 1'b1;
               entry_value_d  = '0;
               entry_digits_d = '0;
            end
         end else if (entry_digits_q < DIGITS_W'(MAX_DIGITS)) begin
            entry_value_d  = ENTRY_W'(entry_value_q * ENTRY_W'(10)) + ENTRY_W'(key_code_q);
            entry_digits_d = entry_digits_q + DIGITS_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         cand_q         <= KEY_NONE;
         cnt_q          <= '0;
         key_pulse_q    <= 1'b0;
         key_code_q     <= '0;
         entry_value_q  <= '0;
         entry_digits_q <= '0;
         value_q        <= '0;
         value_valid_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cand_q         <= cand_d;
         cnt_q          <= cnt_d;
         key_pulse_q    <= key_pulse_d;
         key_code_q     <= key_code_d;
         entry_value_q  <= entry_value_d;
         entry_digits_q <= entry_digits_d;
         value_q        <= value_d;
         value_valid_q  <= value_valid_d;
      end
   end

   assign key_pulse    = key_pulse_q;
   assign key_code     = key_code_q;
   assign entry_value  = entry_value_q;
   assign entry_digits = entry_digits_q;
   assign value        = value_q;
   assign value_valid  = value_valid_q;

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Directed bench for keypad_entry_unit with a keypad matrix model and an event scoreboard.
module tb_keypad_entry_unit;

   localparam int SCAN = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] key_ROW;
   logic [2:0] key_COL;
   logic       key_pulse;
   logic [3:0] key_code;
   logic [9:0] entry_value;
   logic [1:0] entry_digits;
   logic [7:0] value;
   logic       value_valid;

   logic [11:0] keys_pressed;

   int n_cmp = 0;
   int n_err = 0;
   int exp_key_q[$];
   int exp_val_q[$];
   int m_entry, m_digits, m_value;

   keypad_entry_unit #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .key_ROW      (key_ROW),
      .key_COL      (key_COL),
      .key_pulse    (key_pulse),
      .key_code     (key_code),
      .entry_value  (entry_value),
      .entry_digits (entry_digits),
      .value        (value),
      .value_valid  (value_valid)
   );

   always #5 clk = ~clk;

   function automatic int row_of(int c);
      if (c >= 1 && c <= 9) return (c - 1) / 3;
      return 3;
   endfunction

   function automatic int col_of(int c);
      if (c >= 1 && c <= 9) return (c - 1) % 3;
      if (c == 10) return 0;
      if (c == 0) return 1;
      return 2;
   endfunction

   // Passive matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      key_ROW = 4'hF;
      for (int c = 0; c < 12; c++) begin
         if (keys_pressed[c] && key_COL[col_of(c)] == 1'b0) key_ROW[row_of(c)] = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Scoreboard pop side.
   always @(negedge clk) begin
      if (key_pulse === 1'b1) begin
         if (exp_key_q.size() == 0) check("unexpected_key_pulse", 32'd1, 32'd0);
         else check("key_code", 32'(key_code), 32'(exp_key_q.pop_front()));
      end
      if (value_valid === 1'b1) begin
         if (exp_val_q.size() == 0) check("unexpected_value_valid", 32'd1, 32'd0);
         else check("value", 32'(value), 32'(exp_val_q.pop_front()));
      end
   end

   task automatic model_key(input int k);
      exp_key_q.push_back(k);
      if (k == 10) begin
         m_entry = 0; m_digits = 0;
      end else if (k == 11) begin
         if (m_digits > 0) begin
            m_value = (m_entry > 255) ? 255 : m_entry;
            exp_val_q.push_back(m_value);
            m_entry = 0; m_digits = 0;
         end
      end else if (m_digits < 3) begin
         m_entry = m_entry * 10 + k;
         m_digits++;
      end
   endtask

   task automatic press_key(input int k, input int held, input int gap);
      keys_pressed[k] = 1'b1;
      repeat (held * SCAN) @(posedge clk);
      keys_pressed[k] = 1'b0;
      repeat (gap * SCAN) @(posedge clk);
      #1;
   endtask

   task automatic check_entry(input string tag);
      check({tag, "_entry_value"}, 32'(entry_value), 32'(m_entry));
      check({tag, "_entry_digits"}, 32'(entry_digits), 32'(m_digits));
      check({tag, "_value"}, 32'(value), 32'(m_value));
   endtask

   task automatic tap(input int k);
      model_key(k);
      press_key(k, 5, 5);
      check_entry($sformatf("tap%0d", k));
   endtask

   initial begin
      keys_pressed = '0;
      enable = 1'b1;
      rst = 1'b0;
      m_entry = 0; m_digits = 0; m_value = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_key_col", 32'(key_COL), 32'h7);
      check("rst_key_pulse", 32'(key_pulse), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_value_valid", 32'(value_valid), 32'd0);
      check_entry("rst");
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("scan_col_onehot", 32'($countones(~key_COL)), 32'd1);

      // Basic entry and commit
      tap(1); tap(2); tap(3); tap(11);
      // Clamp and zero commit
      tap(2); tap(5); tap(6); tap(11);
      tap(9); tap(9); tap(9); tap(11);
      tap(0); tap(11);
      // Fourth digit ignored
      tap(1); tap(2); tap(3); tap(4); tap(11);
      // Clear then empty commit
      tap(4); tap(10); tap(11);

      // Too-short press yields nothing
      press_key(5, 2, 5);
      check_entry("short5");

      // Long press with a one-scan glitch yields one event
      model_key(5);
      keys_pressed[5] = 1'b1;
      repeat (10 * SCAN) @(posedge clk);
      keys_pressed[5] = 1'b0;
      repeat (SCAN) @(posedge clk);
      keys_pressed[5] = 1'b1;
      repeat (10 * SCAN) @(posedge clk);
      keys_pressed[5] = 1'b0;
      repeat (5 * SCAN) @(posedge clk);
      #1;
      check_entry("glitch5");

      // Two keys together are rejected until one is released
      keys_pressed[1] = 1'b1;
      keys_pressed[2] = 1'b1;
      repeat (10 * SCAN) @(posedge clk);
      #1;
      check_entry("multi12");
      model_key(1);
      keys_pressed[2] = 1'b0;
      repeat (5 * SCAN) @(posedge clk);
      keys_pressed[1] = 1'b0;
      repeat (5 * SCAN) @(posedge clk);
      #1;
      check_entry("multi_then1");
      tap(10);

      // Disable retains entry and parks the column drive
      tap(7); tap(8);
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("dis_key_col", 32'(key_COL), 32'h7);
      press_key(11, 5, 2);
      check("dis_key_col_after", 32'(key_COL), 32'h7);
      check_entry("disabled");
      enable = 1'b1;
      repeat (2 * SCAN) @(posedge clk);
      #1;
      check_entry("reenabled");

      // Reset mid-entry discards everything
      rst = 1'b0;
      @(posedge clk);
      #1;
      m_entry = 0; m_digits = 0; m_value = 0;
      check("rst2_key_col", 32'(key_COL), 32'h7);
      check("rst2_key_code", 32'(key_code), 32'd0);
      check_entry("rst2");
      rst = 1'b1;
      tap(11);

      check("pending_key_events", 32'(exp_key_q.size()), 32'd0);
      check("pending_value_events", 32'(exp_val_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
